// File: rtl/ecg_pkg.sv
// rtl/ecg_pkg.sv - shared widths and mode constants for the ECG baseline stage
package ecg_pkg;
    localparam int MODE_HP = 0;
    localparam int MODE_LP = 1;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int sum_width(input int dw, input int log2_win);
        return dw + log2_win;
    endfunction

    function automatic int out_width(input int dw);
        return dw + 1;
    endfunction
endpackage

// File: rtl/ecg_win_ram.sv
// rtl/ecg_win_ram.sv - simple dual-port window store, synchronous read with read enable
module ecg_win_ram #(
    parameter int DW    = 12,
    parameter int AW    = 3,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    logic [DW-1:0] mem [DEPTH];

    // Gating the read keeps rd_data frozen while the pipeline is stalled.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end
endmodule

// File: rtl/ecg_baseline_mc.sv
// rtl/ecg_baseline_mc.sv - multi-channel moving-average baseline removal, two-stage pipeline
module ecg_baseline_mc
    import ecg_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int DW       = 12,
    parameter int LOG2_WIN = 2,
    parameter int MODE     = MODE_HP,
    parameter int CW       = clog2_min1(CHANNELS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CW-1:0]        in_ch,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CW-1:0]        out_ch,
    output logic signed [DW:0]   out_data,
    output logic                 out_settled,
    output logic                 ch_err
);
    localparam int WIN      = 1 << LOG2_WIN;
    localparam int SW       = sum_width(DW, LOG2_WIN);
    localparam int OW       = out_width(DW);
    localparam int FW       = LOG2_WIN + 1;
    localparam int AW       = CW + LOG2_WIN;
    localparam int DEPTH    = CHANNELS * WIN;
    localparam bit LOW_PASS = (MODE == MODE_LP);
    localparam logic [FW-1:0]       FILL_FULL = FW'(WIN);
    localparam logic [FW-1:0]       FILL_ONE  = FW'(1);
    localparam logic [LOG2_WIN-1:0] PTR_ONE   = LOG2_WIN'(1);

    logic [LOG2_WIN-1:0]  ptr  [CHANNELS];
    logic signed [SW-1:0] sum  [CHANNELS];
    logic [FW-1:0]        fill [CHANNELS];

    logic                 s1_valid;
    logic [CW-1:0]        s1_ch;
    logic signed [DW-1:0] s1_x;

    logic                 s2_valid;
    logic [CW-1:0]        s2_ch;
    logic signed [DW-1:0] s2_x;
    logic signed [SW-1:0] s2_sum;
    logic [FW-1:0]        s2_fill;
    logic [LOG2_WIN-1:0]  s2_ptr;

    logic                 advance;
    logic                 accept;
    logic                 ch_ok;
    logic                 fwd;
    logic [LOG2_WIN-1:0]  s1_ptr;
    logic signed [SW-1:0] s1_sum;
    logic [FW-1:0]        s1_fill;
    logic signed [DW-1:0] rd_data;
    logic signed [DW-1:0] old_eff;
    logic signed [SW-1:0] sum_next;
    logic signed [SW-1:0] mean_full;
    logic signed [DW-1:0] mean;
    logic [FW-1:0]        fill_next;
    logic signed [OW-1:0] result;

    generate
        if (CHANNELS < (1 << CW)) begin : g_ch_chk
            assign ch_ok = (in_ch < CW'(CHANNELS));
        end else begin : g_ch_all
            assign ch_ok = 1'b1;
        end
    endgenerate

    assign advance  = !out_valid || out_ready;
    assign in_ready = !rst && (!s1_valid || advance);
    assign accept   = in_valid && in_ready;

    ecg_win_ram #(
        .DW    (DW),
        .AW    (AW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (advance && s2_valid),
        .wr_addr ({s2_ch, s2_ptr}),
        .wr_data (s2_x),
        .rd_en   (advance && s1_valid),
        .rd_addr ({s1_ch, s1_ptr}),
        .rd_data (rd_data)
    );

    // S2 commits the same channel on this edge, so S1 must take its results, not the arrays.
    always_comb begin
        fwd     = s2_valid && (s2_ch == s1_ch);
        s1_ptr  = fwd ? s2_ptr + PTR_ONE : ptr[s1_ch];
        s1_sum  = fwd ? sum_next : sum[s1_ch];
        s1_fill = fwd ? fill_next : fill[s1_ch];
    end

    always_comb begin
        old_eff   = (s2_fill < FILL_FULL) ? '0 : rd_data;
        sum_next  = s2_sum + SW'(s2_x) - SW'(old_eff);
        mean_full = sum_next >>> LOG2_WIN;
        mean      = DW'(mean_full);
        fill_next = (s2_fill == FILL_FULL) ? s2_fill : s2_fill + FILL_ONE;
        result    = LOW_PASS ? OW'(mean) : OW'(s2_x) - OW'(mean);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid    <= 1'b0;
            s2_valid    <= 1'b0;
            out_valid   <= 1'b0;
            out_ch      <= '0;
            out_data    <= '0;
            out_settled <= 1'b0;
            ch_err      <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                ptr[i]  <= '0;
                sum[i]  <= '0;
                fill[i] <= '0;
            end
        end else begin
            if (accept && !ch_ok) begin
                ch_err <= 1'b1;
            end
            if (in_ready) begin
                s1_valid <= accept && ch_ok;
            end
            if (accept && ch_ok) begin
                s1_ch <= in_ch;
                s1_x  <= in_data;
            end
            if (advance) begin
                s2_valid  <= s1_valid;
                s2_ch     <= s1_ch;
                s2_x      <= s1_x;
                s2_sum    <= s1_sum;
                s2_fill   <= s1_fill;
                s2_ptr    <= s1_ptr;
                out_valid <= s2_valid;
                if (s2_valid) begin
                    out_ch        <= s2_ch;
                    out_data      <= result;
                    out_settled   <= (fill_next == FILL_FULL);
                    ptr[s2_ch]    <= s2_ptr + PTR_ONE;
                    sum[s2_ch]    <= sum_next;
                    fill[s2_ch]   <= fill_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_ecg_baseline_mc.sv
// tb/tb_ecg_baseline_mc.sv - self-checking bench for ecg_baseline_mc, high-pass and low-pass instances
module tb_ecg_baseline_mc;
    localparam int CHANNELS = 2;
    localparam int DW       = 12;
    localparam int LOG2_WIN = 2;
    localparam int CW       = 2;
    localparam int WIN      = 4;

    logic clk = 1'b0;
    logic rst;
    logic in_valid;
    logic [CW-1:0] in_ch;
    logic signed [DW-1:0] in_data;
    logic out_ready;

    logic hp_in_ready, hp_out_valid, hp_out_settled, hp_ch_err;
    logic lp_in_ready, lp_out_valid, lp_out_settled, lp_ch_err;
    logic [CW-1:0] hp_out_ch, lp_out_ch;
    logic signed [DW:0] hp_out_data, lp_out_data;

    always #5 clk = ~clk;

    ecg_baseline_mc #(.CHANNELS(CHANNELS), .DW(DW), .LOG2_WIN(LOG2_WIN), .MODE(0), .CW(CW)) u_hp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(hp_in_ready), .in_ch(in_ch),
        .in_data(in_data), .out_valid(hp_out_valid), .out_ready(out_ready), .out_ch(hp_out_ch),
        .out_data(hp_out_data), .out_settled(hp_out_settled), .ch_err(hp_ch_err)
    );

    ecg_baseline_mc #(.CHANNELS(CHANNELS), .DW(DW), .LOG2_WIN(LOG2_WIN), .MODE(1), .CW(CW)) u_lp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(lp_in_ready), .in_ch(in_ch),
        .in_data(in_data), .out_valid(lp_out_valid), .out_ready(out_ready), .out_ch(lp_out_ch),
        .out_data(lp_out_data), .out_settled(lp_out_settled), .ch_err(lp_ch_err)
    );

    int n_cmp = 0;
    int n_bad = 0;

    int hist_ch[$];
    int hist_x[$];
    int exp_ch[$];
    int exp_hp[$];
    int exp_lp[$];
    int exp_set[$];
    int got_ch[$];
    int got_hp[$];
    int got_lp[$];
    int got_set[$];
    int exp_list[$];
    int model_err;
    int n_acc;
    bit stall_prev;
    int prev_ch, prev_data, prev_set;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_list(input string tag, input int got[$], input int exp[$]);
        chk({tag, "_count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            chk($sformatf("%s[%0d]", tag, i), got[i], exp[i]);
        end
    endtask

    function automatic int floor_div(input int s);
        if (s >= 0) return s / WIN;
        return -((-s + WIN - 1) / WIN);
    endfunction

    // Mean over the last WIN accepted samples of the channel, divided by WIN even while filling.
    task automatic model_push(input int ch, input int x);
        int s;
        int cnt;
        int m;
        if (ch >= CHANNELS) begin
            model_err = 1;
            return;
        end
        n_acc++;
        hist_ch.push_back(ch);
        hist_x.push_back(x);
        s = 0;
        cnt = 0;
        for (int i = hist_ch.size() - 1; i >= 0 && cnt < WIN; i--) begin
            if (hist_ch[i] == ch) begin
                s += hist_x[i];
                cnt++;
            end
        end
        m = floor_div(s);
        exp_ch.push_back(ch);
        exp_hp.push_back(x - m);
        exp_lp.push_back(m);
        exp_set.push_back(int'(cnt == WIN));
    endtask

    task automatic clear_model();
        hist_ch.delete(); hist_x.delete();
        exp_ch.delete(); exp_hp.delete(); exp_lp.delete(); exp_set.delete();
        got_ch.delete(); got_hp.delete(); got_lp.delete(); got_set.delete();
        model_err = 0;
        n_acc = 0;
        stall_prev = 1'b0;
    endtask

    task automatic cycle(input bit v, input int ch, input int d, input bit ordy);
        @(negedge clk);
        in_valid  = v;
        in_ch     = CW'(ch);
        in_data   = DW'(d);
        out_ready = ordy;
        #1;
        if (stall_prev) begin
            chk("stall_valid", hp_out_valid, 1);
            chk("stall_ch", hp_out_ch, prev_ch);
            chk("stall_data", hp_out_data, prev_data);
            chk("stall_settled", hp_out_settled, prev_set);
        end
        if (hp_out_valid && out_ready) begin
            if (exp_ch.size() == 0) begin
                chk("spurious_output", 1, 0);
            end else begin
                chk("out_ch", hp_out_ch, exp_ch[0]);
                chk("hp_data", hp_out_data, exp_hp[0]);
                chk("hp_settled", hp_out_settled, exp_set[0]);
                chk("lp_valid", lp_out_valid, 1);
                chk("lp_data", lp_out_data, exp_lp[0]);
                chk("lp_settled", lp_out_settled, exp_set[0]);
                void'(exp_ch.pop_front()); void'(exp_hp.pop_front());
                void'(exp_lp.pop_front()); void'(exp_set.pop_front());
            end
            got_ch.push_back(int'(hp_out_ch));
            got_hp.push_back(int'(hp_out_data));
            got_lp.push_back(int'(lp_out_data));
            got_set.push_back(int'(hp_out_settled));
        end
        stall_prev = hp_out_valid && !out_ready;
        prev_ch    = int'(hp_out_ch);
        prev_data  = int'(hp_out_data);
        prev_set   = int'(hp_out_settled);
        if (v && hp_in_ready) model_push(ch, d);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_ch.size() != 0 && n < 50) begin
            cycle(1'b0, 0, 0, 1'b1);
            n++;
        end
        chk("drain_pending", exp_ch.size(), 0);
        repeat (3) cycle(1'b0, 0, 0, 1'b1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", hp_in_ready, 0);
        chk("rst_out_valid", hp_out_valid, 0);
        chk("rst_out_ch", hp_out_ch, 0);
        chk("rst_out_data", hp_out_data, 0);
        chk("rst_out_settled", hp_out_settled, 0);
        chk("rst_ch_err", hp_ch_err, 0);
        chk("rst_lp_out_valid", lp_out_valid, 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", hp_in_ready, 1);
        clear_model();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit dropped;
        rst = 1'b1; in_valid = 1'b0; in_ch = '0; in_data = '0; out_ready = 1'b1;
        clear_model();

        // Constant input settles to zero once the window is full.
        do_reset();
        repeat (5) cycle(1'b1, 0, 100, 1'b1);
        drain();
        exp_list = '{75, 50, 25, 0, 0};
        check_list("s1_hp", got_hp, exp_list);
        exp_list = '{0, 0, 0, 1, 1};
        check_list("s1_settled", got_set, exp_list);

        // Interleaved channels keep independent windows.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 0, 8, 1'b1);
            cycle(1'b1, 1, -8, 1'b1);
        end
        drain();
        exp_list = '{2, -2, 4, -4, 6, -6, 8, -8};
        check_list("s2_lp", got_lp, exp_list);
        exp_list = '{0, 1, 0, 1, 0, 1, 0, 1};
        check_list("s2_ch", got_ch, exp_list);

        // Back-to-back same channel exercises forwarding.
        do_reset();
        for (int i = 1; i <= 5; i++) cycle(1'b1, 0, 4 * i, 1'b1);
        drain();
        exp_list = '{3, 5, 6, 6, 6};
        check_list("s3_hp", got_hp, exp_list);

        // Downstream stall with input held valid.
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1'b1, 0, 10 * i + 1, 1'b1);
        dropped = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle(1'b1, i % 2, 50 + i, 1'b0);
            if (!hp_in_ready) dropped = 1'b1;
        end
        chk("s4_in_ready_dropped", dropped, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1, -30 - i, 1'b1);
        drain();
        chk("s4_all_emerged", got_hp.size(), n_acc);

        // Full-scale extremes and floor rounding of a negative mean.
        do_reset();
        repeat (4) cycle(1'b1, 0, -2048, 1'b1);
        cycle(1'b1, 0, 2047, 1'b1);
        drain();
        exp_list = '{-1536, -1024, -512, 0, 3072};
        check_list("s5_hp", got_hp, exp_list);

        // Out-of-range channel is discarded and flagged until reset.
        do_reset();
        cycle(1'b1, 3, 55, 1'b1);
        chk("s6_bad_ch_accepted", model_err, 1);
        repeat (4) cycle(1'b0, 0, 0, 1'b1);
        chk("s6_no_output", got_hp.size(), 0);
        chk("s6_ch_err", hp_ch_err, 1);
        do_reset();
        cycle(1'b1, 0, 100, 1'b1);
        drain();
        exp_list = '{75};
        check_list("s6_refill", got_hp, exp_list);

        // Randomised traffic against the reference model.
        do_reset();
        for (int i = 0; i < 1500; i++) begin
            int ch;
            ch = ($urandom_range(0, 15) == 0) ? 3 : int'($urandom_range(0, 1));
            cycle($urandom_range(0, 3) != 0, ch, int'($urandom_range(0, 4095)) - 2048,
                  $urandom_range(0, 3) != 0);
        end
        drain();
        chk("rand_all_emerged", got_hp.size(), n_acc);
        chk("rand_ch_err_hp", hp_ch_err, model_err);
        chk("rand_ch_err_lp", lp_ch_err, model_err);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
